fpu_arbiter: RTL
================

# fpu_arbiter

Two-port arbiter and sequencer that shares the single-issue floating-point arithmetic unit between two requesters (integer pipeline FPU issue port and the debug/microcode port). It grants one requester at a time with round-robin fairness and holds exactly one operation in flight. It routes the result and exception flags back to the owning requester, and it also drives the unit's issue and result handshakes and its flush. It sits between the requesters and the operand unpacker that feeds the arithmetic unit.

## Interface
- No parameters; widths are fixed at op 5, rm 3, operand/result 32, flags 5 (order IV, DZ, OF, UF, IE, MSB first).
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  abort in-flight operation; forwarded to the unit.
- req_valid_0 / req_valid_1  in  1  request pending.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle.
- req_op_k  in  5  operation code for requester k.
- req_rm_k  in  3  rounding mode for requester k.
- req_a_k / req_b_k  in  32  operands for requester k.
- rsp_valid_0 / rsp_valid_1  out  1  result available to the owner.
- rsp_ready_0 / rsp_ready_1  in  1  owner accepts the result.
- rsp_data  out  32  result, shared by both ports.
- rsp_flags  out  5  exception flags, shared by both ports.
- fpu_valid  out  1  issue valid to the unit.
- fpu_ready  in  1  unit ready to issue.
- fpu_op  out  5  operation code to the unit.
- fpu_rm  out  3  rounding mode to the unit.
- fpu_a / fpu_b  out  32  operands to the unit.
- fpu_flush  out  1  equals flush, combinational.
- fpu_res_valid  in  1  unit result valid.
- fpu_res_ready  out  1  arbiter accepts the unit's result.
- fpu_res  in  32  unit result.
- fpu_flags  in  5  unit exception flags.
- clr_flags_0 / clr_flags_1  in  1  clear the sticky flags for requester k (present only with the macro).
- acc_flags_0 / acc_flags_1  out  5  sticky accumulated flags for requester k (present only with the macro).

## Operation
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not equal to the last_grant pointer.
  - req_ready_k is asserted combinationally for the granted k only.
  - On grant, latch op/rm/a/b and set owner=k and last_grant=k, then go to ISSUE.
- ISSUE:
  - fpu_valid=1 with the latched fields held stable.
  - On fpu_valid && fpu_ready, go to WAIT.
- WAIT:
  - fpu_res_ready=1.
  - On fpu_res_valid, latch fpu_res and fpu_flags into rsp_data/rsp_flags, then go to RESP.
- RESP:
  - rsp_valid_owner=1; the other port's rsp_valid stays 0.
  - On rsp_ready_owner, go to IDLE.
  - No new grant is made in this cycle.
- rsp_data/rsp_flags hold their value until the next capture.
- fpu_res_valid outside WAIT is ignored and fpu_res_ready stays 0.
- rm=3'b111 (dynamic) is passed through unchanged; resolution happens upstream.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), owner=0.
  - All req_ready, rsp_valid, fpu_valid and fpu_res_ready are 0.
  - rsp_data=0, rsp_flags=0, acc_flags=0.
- Minimum occupancy with the unit always ready and a result latency of L cycles: accept at cycle 0, issue at cycle 1, result captured at cycle 1+L, rsp_valid at cycle 2+L.
- Next grant is no earlier than the cycle after the response handshake.
- A requester that keeps req_valid high through its own response loses the next tie to the other requester.
- flush in any state:
  - Next state is IDLE.
  - No rsp_valid for the aborted operation and no flag accumulation.
  - last_grant is kept.
  - req_ready is forced to 0 in the flush cycle.
- reset has priority over flush.
- Reset mid-operation drops everything; the unit is reset by the same signal.

## Configuration
- FPU_ARB_FFLAGS_EN defined:
  - Per-requester 5-bit sticky registers.
  - On the RESP handshake, acc_flags_owner |= rsp_flags.
  - clr_flags_k clears register k.
  - If clear and accumulate for the same k coincide, the result is rsp_flags (clear first, then OR).
- FPU_ARB_FFLAGS_EN undefined: the clr/acc ports and the registers are absent; behaviour is otherwise identical.

## Test plan
- Single request, unit latency L=3:
  - req_valid_0, op=ADD, a=0x3F800000, b=0x40000000; unit returns 0x40400000, flags 0.
  - Required: req_ready_0 at cycle 0, fpu_valid at cycle 1, rsp_valid_0 at cycle 5 with rsp_data=0x40400000 and rsp_valid_1=0.
- Both ports valid continuously for 4 operations: grants are 0,1,0,1 and each response appears only on the owner's port.
- fpu_ready held low 5 cycles in ISSUE: fpu_valid and fpu_a/fpu_b stay stable, then WAIT is entered on the cycle fpu_ready rises.
- flush asserted in WAIT: fpu_flush=1 the same cycle, no rsp_valid, IDLE next cycle, and a pending req_valid_1 is granted the following cycle.
- Backpressure: rsp_ready_1=0 for 3 cycles while fpu_res_valid pulses again; rsp_data is unchanged and fpu_res_ready stays 0.
- With FPU_ARB_FFLAGS_EN:
  - Two requester-0 ops return flags 5'b00001 then 5'b00100: acc_flags_0=5'b00101.
  - clr_flags_0 in the cycle of a 5'b10000 response: acc_flags_0=5'b10000.

Source files
------------

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: two-port round-robin arbiter and sequencer for a shared
// single-issue FPU. One operation is in flight at a time. The result and flags
// are returned to the requester that owns the operation.
// Optional feature: define FPU_ARB_FFLAGS_EN to add per-requester sticky
// exception-flag registers with clear inputs.
module fpu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [4:0]  req_op_0,
    input  logic [4:0]  req_op_1,
    input  logic [2:0]  req_rm_0,
    input  logic [2:0]  req_rm_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_flags,
    output logic        fpu_valid,
    input  logic        fpu_ready,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_res_valid,
    output logic        fpu_res_ready,
    input  logic [31:0] fpu_res,
    input  logic [4:0]  fpu_flags,
`ifdef FPU_ARB_FFLAGS_EN
    input  logic        clr_flags_0,
    input  logic        clr_flags_1,
    output logic [4:0]  acc_flags_0,
    output logic [4:0]  acc_flags_1,
`endif
    output logic        fpu_flush
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [4:0]  op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [4:0]  rsp_flags_q, rsp_flags_d;

    logic        grant_s;      // a grant is made this cycle
    logic        grant_sel_s;  // which requester is granted
    logic        rsp_done_s;   // response handshake with the owner completes

    // Sequencer next-state: round-robin grant, issue, result capture, response
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        rm_d         = rm_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        grant_s      = 1'b0;
        grant_sel_s  = 1'b0;
        rsp_done_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not win last time is chosen
                if (req_valid_0 && req_valid_1) begin
                    grant_s     = 1'b1;
                    grant_sel_s = ~last_grant_q;
                end else if (req_valid_0) begin
                    grant_s     = 1'b1;
                    grant_sel_s = 1'b0;
                end else if (req_valid_1) begin
                    grant_s     = 1'b1;
                    grant_sel_s = 1'b1;
                end else begin
                    grant_s     = 1'b0;
                    grant_sel_s = 1'b0;
                end
                // No acceptance while the pipe is being flushed or reset
                grant_s = grant_s & ~flush & ~reset;
                if (grant_s) begin
                    state_d      = ST_ISSUE;
                    owner_d      = grant_sel_s;
                    last_grant_d = grant_sel_s;
                    op_d         = grant_sel_s ? req_op_1 : req_op_0;
                    rm_d         = grant_sel_s ? req_rm_1 : req_rm_0;
                    a_d          = grant_sel_s ? req_a_1  : req_a_0;
                    b_d          = grant_sel_s ? req_b_1  : req_b_0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fpu_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (fpu_res_valid) begin
                    rsp_data_d  = fpu_res;
                    rsp_flags_d = fpu_flags;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                rsp_done_s = owner_q ? rsp_ready_1 : rsp_ready_0;
                if (rsp_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush aborts the operation: back to IDLE, nothing captured or delivered
        if (flush) begin
            state_d     = ST_IDLE;
            rsp_data_d  = rsp_data_q;
            rsp_flags_d = rsp_flags_q;
            rsp_done_s  = 1'b0;
        end else begin
            rsp_done_s = rsp_done_s;
        end
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= 5'd0;
            rm_q         <= 3'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rsp_data_q   <= 32'd0;
            rsp_flags_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            rm_q         <= rm_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign req_ready_0   = grant_s & ~grant_sel_s;
    assign req_ready_1   = grant_s & grant_sel_s;
    assign fpu_valid     = (state_q == ST_ISSUE);
    assign fpu_op        = op_q;
    assign fpu_rm        = rm_q;
    assign fpu_a         = a_q;
    assign fpu_b         = b_q;
    assign fpu_res_ready = (state_q == ST_WAIT);
    assign rsp_valid_0   = (state_q == ST_RESP) & ~owner_q & ~flush;
    assign rsp_valid_1   = (state_q == ST_RESP) & owner_q & ~flush;
    assign rsp_data      = rsp_data_q;
    assign rsp_flags     = rsp_flags_q;
    assign fpu_flush     = flush;

`ifdef FPU_ARB_FFLAGS_EN
    logic [4:0] acc_0_q, acc_0_d;
    logic [4:0] acc_1_q, acc_1_d;

    // Sticky flags: clear first, then OR in the flags of a completed response
    always_comb begin
        acc_0_d = clr_flags_0 ? 5'b00000 : acc_0_q;
        acc_1_d = clr_flags_1 ? 5'b00000 : acc_1_q;
        if (rsp_done_s && !owner_q) begin
            acc_0_d = acc_0_d | rsp_flags_q;
        end else begin
            acc_0_d = acc_0_d;
        end
        if (rsp_done_s && owner_q) begin
            acc_1_d = acc_1_d | rsp_flags_q;
        end else begin
            acc_1_d = acc_1_d;
        end
    end

    // Sticky flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_0_q <= 5'd0;
            acc_1_q <= 5'd0;
        end else begin
            acc_0_q <= acc_0_d;
            acc_1_q <= acc_1_d;
        end
    end

    assign acc_flags_0 = acc_0_q;
    assign acc_flags_1 = acc_1_q;
`endif

endmodule
